// File: rtl/sp_return_unit.sv
// Stack-pointer return unit: pops a return address from stack memory through a
// req/ack read and releases SP = SP + 2, flagging pops from an empty stack.
module sp_return_unit #(
  parameter int unsigned   W        = 16,
  parameter logic [W-1:0]  SP_EMPTY = 16'hFFFE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_stack,
  input  logic         ret_enable,
  output logic         mem_req,
  output logic [W-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic [W-1:0] output_stack,
  output logic [W-1:0] ret_addr,
  output logic         ret_valid,
  output logic         underflow,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e       state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic [W-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0] out_sp_q, out_sp_d;
  logic [W-1:0] ret_addr_q, ret_addr_d;
  logic         ret_valid_q, ret_valid_d;
  logic         underflow_q, underflow_d;
  logic         busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    out_sp_d    = out_sp_q;
    ret_addr_d  = ret_addr_q;
    ret_valid_d = 1'b0;
    underflow_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        out_sp_d  = input_stack;
        mem_req_d = 1'b0;
        if (ret_enable) begin
          if (input_stack == SP_EMPTY) begin
            underflow_d = 1'b1;
          end else begin
            // mem_addr doubles as the latched SP for the whole pop.
            mem_addr_d = input_stack;
            mem_req_d  = 1'b1;
            state_d    = StRead;
          end
        end
      end
      StRead: begin
        if (mem_ack) begin
          ret_addr_d  = mem_rdata;
          out_sp_d    = mem_addr_q + W'(2);
          mem_req_d   = 1'b0;
          ret_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      out_sp_q    <= SP_EMPTY;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      out_sp_q    <= out_sp_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign output_stack = out_sp_q;
  assign ret_addr     = ret_addr_q;
  assign ret_valid    = ret_valid_q;
  assign underflow    = underflow_q;
  assign busy         = busy_q;

endmodule
